// File: rtl/sdram_port_arbiter.sv
// sdram_port_arbiter: round-robin scheduler for the shared SDRAM command engine.
// Arbitrates WB_PORTS buffered wishbone front-ends plus the refresh timer.
// Refresh wins every arbitration point. A grant is held until the sequencer
// reports the burst complete.
`timescale 1ns/1ps
module sdram_port_arbiter #(
    parameter int unsigned WB_PORTS  = 4,
    parameter int unsigned ADR_WIDTH = 23
) (
    input  logic                          sdram_clk,
    input  logic                          sdram_rst,
    input  logic [WB_PORTS-1:0]           req_i,
    input  logic [WB_PORTS-1:0]           we_i,
    input  logic [WB_PORTS*ADR_WIDTH-1:0] adr_i,
    output logic [WB_PORTS-1:0]           gnt_o,
    output logic [WB_PORTS-1:0]           done_o,
    input  logic                          ref_req_i,
    output logic                          ref_gnt_o,
    input  logic                          ref_done_i,
    output logic                          ctrl_req_o,
    output logic                          ctrl_we_o,
    output logic [ADR_WIDTH-1:0]          ctrl_adr_o,
    input  logic                          ctrl_ack_i,
    input  logic                          ctrl_done_i,
    output logic                          busy_o
);

    localparam int unsigned PTR_W = (WB_PORTS > 1) ? $clog2(WB_PORTS) : 1;

    typedef enum logic [1:0] {
        ST_IDLE    = 2'd0,
        ST_ISSUE   = 2'd1,
        ST_WAIT    = 2'd2,
        ST_REFRESH = 2'd3
    } state_e;

    state_e                 state_q,   state_d;
    logic [PTR_W-1:0]       last_q,    last_d;
    logic [PTR_W-1:0]       sel_q,     sel_d;
    logic [WB_PORTS-1:0]    gnt_q,     gnt_d;
    logic [WB_PORTS-1:0]    done_q,    done_d;
    logic                   ref_gnt_q, ref_gnt_d;
    logic                   ctrl_req_q, ctrl_req_d;
    logic                   ctrl_we_q, ctrl_we_d;
    logic [ADR_WIDTH-1:0]   ctrl_adr_q, ctrl_adr_d;
    logic                   busy_q,    busy_d;

    logic [ADR_WIDTH-1:0]   adr_arr_c [WB_PORTS];
    logic [PTR_W-1:0]       rr_sel_c;
    logic                   rr_found_c;
    int unsigned            rr_idx;

    // Split the flat address bus into one word per port.
    for (genvar g = 0; g < WB_PORTS; g++) begin : g_adr
        assign adr_arr_c[g] = adr_i[g*ADR_WIDTH +: ADR_WIDTH];
    end

    // Round-robin search: first asserted port starting just after the last winner.
    always_comb begin
        rr_found_c = 1'b0;
        rr_sel_c   = '0;
        rr_idx     = 0;
        for (int unsigned k = 1; k <= WB_PORTS; k++) begin
            rr_idx = 32'(last_q) + k;
            if (rr_idx >= WB_PORTS) begin
                rr_idx = rr_idx - WB_PORTS;
            end
            if (!rr_found_c && req_i[PTR_W'(rr_idx)]) begin
                rr_found_c = 1'b1;
                rr_sel_c   = PTR_W'(rr_idx);
            end
        end
    end

    // Next-state and next-output logic for the arbitration FSM.
    always_comb begin
        state_d    = state_q;
        last_d     = last_q;
        sel_d      = sel_q;
        gnt_d      = gnt_q;
        done_d     = '0;
        ref_gnt_d  = ref_gnt_q;
        ctrl_req_d = ctrl_req_q;
        ctrl_we_d  = ctrl_we_q;
        ctrl_adr_d = ctrl_adr_q;

        case (state_q)
            ST_IDLE: begin
                if (ref_req_i) begin
                    ref_gnt_d = 1'b1;
                    state_d   = ST_REFRESH;
                end else if (rr_found_c) begin
                    sel_d      = rr_sel_c;
                    gnt_d      = WB_PORTS'(1) << rr_sel_c;
                    ctrl_we_d  = we_i[rr_sel_c];
                    ctrl_adr_d = adr_arr_c[rr_sel_c];
                    ctrl_req_d = 1'b1;
                    state_d    = ST_ISSUE;
                end
            end
            ST_ISSUE: begin
                if (ctrl_ack_i) begin
                    ctrl_req_d = 1'b0;
                    if (ctrl_done_i) begin
                        // Accept and completion in one cycle: finish the burst now.
                        done_d  = gnt_q;
                        gnt_d   = '0;
                        last_d  = sel_q;
                        state_d = ST_IDLE;
                    end else begin
                        state_d = ST_WAIT;
                    end
                end
            end
            ST_WAIT: begin
                if (ctrl_done_i) begin
                    done_d  = gnt_q;
                    gnt_d   = '0;
                    last_d  = sel_q;
                    state_d = ST_IDLE;
                end
            end
            ST_REFRESH: begin
                // Refresh does not move the round-robin pointer.
                if (ref_done_i) begin
                    ref_gnt_d = 1'b0;
                    state_d   = ST_IDLE;
                end
            end
            default: begin
                state_d = ST_IDLE;
            end
        endcase

        busy_d = (state_d != ST_IDLE);
    end

    // State and output registers with synchronous reset.
    always_ff @(posedge sdram_clk) begin
        if (sdram_rst) begin
            state_q    <= ST_IDLE;
            last_q     <= PTR_W'(WB_PORTS - 1);
            sel_q      <= '0;
            gnt_q      <= '0;
            done_q     <= '0;
            ref_gnt_q  <= 1'b0;
            ctrl_req_q <= 1'b0;
            ctrl_we_q  <= 1'b0;
            ctrl_adr_q <= '0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            last_q     <= last_d;
            sel_q      <= sel_d;
            gnt_q      <= gnt_d;
            done_q     <= done_d;
            ref_gnt_q  <= ref_gnt_d;
            ctrl_req_q <= ctrl_req_d;
            ctrl_we_q  <= ctrl_we_d;
            ctrl_adr_q <= ctrl_adr_d;
            busy_q     <= busy_d;
        end
    end

    assign gnt_o      = gnt_q;
    assign done_o     = done_q;
    assign ref_gnt_o  = ref_gnt_q;
    assign ctrl_req_o = ctrl_req_q;
    assign ctrl_we_o  = ctrl_we_q;
    assign ctrl_adr_o = ctrl_adr_q;
    assign busy_o     = busy_q;

endmodule

// File: doc/sdram_port_arbiter.md
Name: sdram_port_arbiter

Overview:
Round-robin scheduler that shares the single SDRAM command/burst engine between WB_PORTS buffered wishbone port front-ends and the refresh timer.
- Runs entirely in the SDRAM clock domain, after each port's clock-domain-crossing buffer and before the SDRAM command sequencer.
- Grants one requester at a time and forwards its address and direction.
- Holds the grant until the sequencer reports the burst complete.
- Refresh has priority at every arbitration point.

Parameters:
WB_PORTS, 4, number of requesting ports (1..8).
ADR_WIDTH, 23, word address width forwarded to the sequencer (BA+ROW+COL).

Ports:
sdram_clk  in  1  SDRAM clock; all logic on rising edge.
sdram_rst  in  1  synchronous, active-high reset.
req_i  in  WB_PORTS  per-port access request; level; held by port until its done_o pulse.
we_i  in  WB_PORTS  per-port direction, 1 = write burst.
adr_i  in  WB_PORTS*ADR_WIDTH  per-port burst start address; port i at [i*ADR_WIDTH +: ADR_WIDTH].
gnt_o  out  WB_PORTS  one-hot grant; selects which port buffer drives/receives data.
done_o  out  WB_PORTS  one-cycle pulse to the granted port when its burst is complete.
ref_req_i  in  1  refresh request from refresh timer; level; held until ref_done_i.
ref_gnt_o  out  1  refresh granted; sequencer issues PRE-all + REF.
ref_done_i  in  1  one-cycle pulse, refresh sequence finished.
ctrl_req_o  out  1  command request to sequencer.
ctrl_we_o  out  1  latched direction of granted port.
ctrl_adr_o  out  ADR_WIDTH  latched address of granted port.
ctrl_ack_i  in  1  sequencer accepted the command (pulse).
ctrl_done_i  in  1  sequencer finished the burst (pulse).
busy_o  out  1  state != IDLE.

Behaviour:
- All outputs are registered.
- Reset values: gnt_o=0, done_o=0, ref_gnt_o=0, ctrl_req_o=0, ctrl_we_o=0, ctrl_adr_o=0, busy_o=0, state=IDLE, last pointer=WB_PORTS-1 (so port 0 has first priority).
- Reset taken in any state aborts the operation immediately; outputs take reset values after the next edge.
- FSM states: IDLE, ISSUE, WAIT, REFRESH.
- IDLE:
  - If ref_req_i=1: ref_gnt_o<=1, go to REFRESH. Refresh wins over any simultaneous port request.
  - Else if |req_i: pick the first asserted port searching last+1, last+2, ... modulo WB_PORTS. Then gnt_o<=onehot(sel), ctrl_we_o<=we_i[sel], ctrl_adr_o<=adr_i[sel], ctrl_req_o<=1, go to ISSUE.
  - Latency: req_i sampled at edge N; gnt_o/ctrl_req_o are high from edge N.
- ISSUE:
  - Hold ctrl_req_o and the latched address/direction until ctrl_ack_i.
  - On ctrl_ack_i alone: ctrl_req_o<=0, go to WAIT.
  - On ctrl_ack_i and ctrl_done_i in the same cycle: treat as done. Same actions as the WAIT completion below, go to IDLE.
- WAIT:
  - On ctrl_done_i: done_o[sel]<=1 for exactly one cycle, gnt_o<=0, last<=sel, go to IDLE.
- REFRESH:
  - Hold ref_gnt_o until ref_done_i; then ref_gnt_o<=0, go to IDLE.
  - The last pointer is unchanged by refresh.
- Minimum one IDLE cycle between consecutive grants. Back-to-back bursts therefore cost 1 arbitration cycle.
- ref_req_i asserted during ISSUE/WAIT is not serviced mid-burst; it is served at the next IDLE, before any port.
- Changes on req_i/we_i/adr_i of the granted port after the grant are ignored; the latched values are used.
- Deassertion of req_i by the granted port does not abort the burst.
- A port still asserting req_i in the cycle after its done_o is re-arbitrated normally; round-robin places it last.
- ctrl_ack_i/ctrl_done_i/ref_done_i arriving in an unexpected state are ignored.
- WB_PORTS=1: pointer logic degenerates; port 0 is always selected.

Test Plan:
- Reset release, then req_i=0001, adr port0=0x000100, we=0 -> next cycle gnt_o=0001, ctrl_req_o=1, ctrl_adr_o=0x000100, ctrl_we_o=0. ctrl_ack_i 3 cycles later -> ctrl_req_o=0. ctrl_done_i -> done_o=0001 for one cycle, gnt_o=0000, busy_o=0.
- req_i=1111 held continuously, sequencer acks/dones each burst -> grant order 0,1,2,3,0,1. Exactly one done_o pulse per grant, never two gnt_o bits set.
- ref_req_i=1 and req_i=0100 asserted in the same IDLE cycle -> ref_gnt_o=1, gnt_o=0000 until ref_done_i. Then one IDLE cycle, then gnt_o=0100.
- ref_req_i rises while in WAIT for port 1, with req_i[3] also pending -> ref_gnt_o stays 0 until done_o[1]. Refresh is granted next, then port 3.
- ctrl_ack_i and ctrl_done_i pulse together in ISSUE -> single done_o pulse, return to IDLE, no second ctrl_req_o for that burst.
- sdram_rst pulsed for 1 cycle during WAIT for port 2 -> all outputs 0 after the edge. Then req_i=1001 -> port 0 granted first, then port 3.
